mouse_sequence_decoder: RTL and testbench

Receive-side parser for the 4-byte mouse report sequence produced by the terminal's mouse encoder: 0x1E, X byte, Y byte, modifier byte. The block consumes a byte stream, one byte per valid cycle, and rebuilds the text-cell position, button state and keyboard modifiers as a single-cycle event. Bytes that are not part of a sequence are forwarded unchanged. It sits on the loopback/host-input path, used for self-test and for chaining terminals.

---
 rtl/mouse_sequence_decoder_pkg.sv | 23 ++
 rtl/mouse_sequence_decoder_sat_counter8.sv | 28 ++
 rtl/mouse_sequence_decoder.sv | 153 +++++++++++++++
 tb/tb_mouse_sequence_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_sequence_decoder_pkg.sv
// Shared constants for the mouse report sequence decoder: start byte,
// modifier bit positions and FSM state encoding.
package mouse_sequence_decoder_pkg;

    localparam logic [7:0] MOUSE_SEQ_START = 8'h1E;

    localparam int MOD_LEFT   = 0;
    localparam int MOD_RIGHT  = 1;
    localparam int MOD_MIDDLE = 2;
    localparam int MOD_SHIFT  = 3;
    localparam int MOD_CTRL   = 4;
    localparam int MOD_ALT    = 5;
    localparam int MOD_META   = 6;
    localparam int MOD_MARK   = 7;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_X    = 2'd1;
    localparam state_t S_Y    = 2'd2;
    localparam state_t S_MOD  = 2'd3;

endpackage

// File: rtl/mouse_sequence_decoder_sat_counter8.sv
// 8-bit saturating event counter with synchronous active-high reset.
module sat_counter8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mouse_sequence_decoder.sv
// Parses 1E/X/Y/modifier mouse reports from a byte stream into single-cycle events.
// Build option MOUSE_DECODER_PASSTHROUGH_EN forwards non-sequence bytes.
module mouse_sequence_decoder
    import mouse_sequence_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_in_valid,
    output logic       event_valid,
    output logic [6:0] event_x,
    output logic [5:0] event_y,
    output logic [2:0] event_buttons,
    output logic [3:0] event_keys,
    output logic [7:0] passthrough_byte,
    output logic       passthrough_valid,
    output logic [7:0] error_count
);

    state_t     state_q, state_d;
    logic [6:0] x_lat_q, x_lat_d;
    logic [5:0] y_lat_q, y_lat_d;
    logic       ev_valid_q, ev_valid_d;
    logic [6:0] ev_x_q, ev_x_d;
    logic [5:0] ev_y_q, ev_y_d;
    logic [2:0] ev_buttons_q, ev_buttons_d;
    logic [3:0] ev_keys_q, ev_keys_d;
    logic       is_start;
    logic       field_ok;
    logic       fwd;
    logic       err_inc;

    assign is_start = (byte_in == MOUSE_SEQ_START);

    always_comb begin
        state_d      = state_q;
        x_lat_d      = x_lat_q;
        y_lat_d      = y_lat_q;
        ev_valid_d   = 1'b0;
        ev_x_d       = ev_x_q;
        ev_y_d       = ev_y_q;
        ev_buttons_d = ev_buttons_q;
        ev_keys_d    = ev_keys_q;
        fwd          = 1'b0;
        err_inc      = 1'b0;

        case (state_q)
            S_X:     field_ok = byte_in[7];
            S_Y:     field_ok = (byte_in[7:6] == 2'b10);
            S_MOD:   field_ok = byte_in[MOD_MARK];
            default: field_ok = 1'b0;
        endcase

        if (byte_in_valid) begin
            // Start byte wins over the field check, so a 1E mid-sequence restarts.
            if ((state_q != S_IDLE) && (is_start || !field_ok)) begin
                err_inc = 1'b1;
            end
            if ((state_q == S_IDLE) || is_start || !field_ok) begin
                if (is_start) begin
                    state_d = S_X;
                end else begin
                    state_d = S_IDLE;
                    fwd     = 1'b1;
                end
            end else begin
                case (state_q)
                    S_X: begin
                        x_lat_d = byte_in[6:0];
                        state_d = S_Y;
                    end
                    S_Y: begin
                        y_lat_d = byte_in[5:0];
                        state_d = S_MOD;
                    end
                    default: begin
                        ev_valid_d   = 1'b1;
                        ev_x_d       = x_lat_q;
                        ev_y_d       = y_lat_q;
                        ev_buttons_d = {byte_in[MOD_MIDDLE], byte_in[MOD_RIGHT], byte_in[MOD_LEFT]};
                        ev_keys_d    = {byte_in[MOD_META], byte_in[MOD_ALT],
                                        byte_in[MOD_CTRL], byte_in[MOD_SHIFT]};
                        state_d      = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            ev_valid_q   <= 1'b0;
            ev_x_q       <= '0;
            ev_y_q       <= '0;
            ev_buttons_q <= '0;
            ev_keys_q    <= '0;
        end else begin
            state_q      <= state_d;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            ev_valid_q   <= ev_valid_d;
            ev_x_q       <= ev_x_d;
            ev_y_q       <= ev_y_d;
            ev_buttons_q <= ev_buttons_d;
            ev_keys_q    <= ev_keys_d;
        end
    end

    assign event_valid   = ev_valid_q;
    assign event_x       = ev_x_q;
    assign event_y       = ev_y_q;
    assign event_buttons = ev_buttons_q;
    assign event_keys    = ev_keys_q;

`ifdef MOUSE_DECODER_PASSTHROUGH_EN
    logic       pt_valid_q, pt_valid_d;
    logic [7:0] pt_byte_q, pt_byte_d;

    always_comb begin
        pt_valid_d = fwd;
        pt_byte_d  = fwd ? byte_in : pt_byte_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pt_valid_q <= 1'b0;
            pt_byte_q  <= 8'd0;
        end else begin
            pt_valid_q <= pt_valid_d;
            pt_byte_q  <= pt_byte_d;
        end
    end

    assign passthrough_valid = pt_valid_q;
    assign passthrough_byte  = pt_byte_q;
`else
    logic fwd_unused;
    assign fwd_unused        = fwd;
    assign passthrough_valid = 1'b0;
    assign passthrough_byte  = 8'd0;
`endif

    sat_counter8 u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (error_count)
    );

endmodule

// File: tb/tb_mouse_sequence_decoder.sv
// Scoreboard bench for mouse_sequence_decoder: a queue-based reference model
// predicts events/passthrough bytes; a negedge monitor pops and compares.
module tb_mouse_sequence_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_in_valid;
    logic       event_valid;
    logic [6:0] event_x;
    logic [5:0] event_y;
    logic [2:0] event_buttons;
    logic [3:0] event_keys;
    logic [7:0] passthrough_byte;
    logic       passthrough_valid;
    logic [7:0] error_count;

    always #5 clk = ~clk;

    mouse_sequence_decoder dut (
        .clk               (clk),
        .reset             (reset),
        .byte_in           (byte_in),
        .byte_in_valid     (byte_in_valid),
        .event_valid       (event_valid),
        .event_x           (event_x),
        .event_y           (event_y),
        .event_buttons     (event_buttons),
        .event_keys        (event_keys),
        .passthrough_byte  (passthrough_byte),
        .passthrough_valid (passthrough_valid),
        .error_count       (error_count)
    );

    typedef struct {
        logic [19:0] v;
        int          due;
    } exp_t;

    exp_t        ev_q[$];
    exp_t        pt_q[$];
    logic [7:0]  pending[$];
    int          model_err = 0;
    logic [19:0] last_ev = '0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_pass(input logic [7:0] b);
`ifdef MOUSE_DECODER_PASSTHROUGH_EN
        exp_t e;
        e.v   = 20'(b);
        e.due = cyc + 1;
        pt_q.push_back(e);
`else
        if (b === 8'hxx) $display("note: undefined byte dropped");
`endif
    endtask

    task automatic bump_err();
        if (model_err < 255) model_err++;
    endtask

    // Reference model: a sequence is a list of captured bytes; its length is the position.
    task automatic model_step(input logic [7:0] b);
        int   pos;
        logic ok;
        exp_t e;
        pos = pending.size();
        if (pos == 0) begin
            if (b == 8'h1E) pending.push_back(b);
            else push_pass(b);
            return;
        end
        if (b == 8'h1E) begin
            bump_err();
            pending.delete();
            pending.push_back(b);
            return;
        end
        if (pos == 2) ok = (b[7:6] == 2'b10);
        else          ok = b[7];
        if (!ok) begin
            bump_err();
            pending.delete();
            push_pass(b);
            return;
        end
        pending.push_back(b);
        if (pending.size() == 4) begin
            e.v     = {pending[1][6:0], pending[2][5:0], pending[3][2:0], pending[3][6:3]};
            e.due   = cyc + 1;
            last_ev = e.v;
            ev_q.push_back(e);
            pending.delete();
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in       = b;
        byte_in_valid = 1'b1;
        model_step(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_in_valid = 1'b0;
            byte_in       = 8'($urandom);
        end
    endtask

    task automatic send_bytes(input logic [63:0] bs, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            send(bs[8*(n-1-i) +: 8]);
            if (maxgap > 0) idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic chk_state(input string name);
        idle(2);
        check(name, 32'(error_count), 32'(model_err));
        check("hold_fields", 32'({event_x, event_y, event_buttons, event_keys}), 32'(last_ev));
`ifndef MOUSE_DECODER_PASSTHROUGH_EN
        check("pt_byte_tied", 32'(passthrough_byte), 32'd0);
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (event_valid || passthrough_valid) begin
            check("exclusive_valid", 32'(event_valid & passthrough_valid), 32'd0);
        end
        if (event_valid) begin
            if (ev_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=%0h required=none",
                         {event_x, event_y, event_buttons, event_keys});
            end else begin
                e = ev_q.pop_front();
                check("event_fields", 32'({event_x, event_y, event_buttons, event_keys}), 32'(e.v));
                check("event_latency", 32'(cyc), 32'(e.due));
            end
        end
        if (passthrough_valid) begin
            if (pt_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_passthrough actual=%0h required=none", passthrough_byte);
            end else begin
                e = pt_q.pop_front();
                check("pt_byte", 32'(passthrough_byte), 32'(e.v));
                check("pt_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x, y, m;
        reset         = 1'b1;
        byte_in       = 8'd0;
        byte_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_event_valid", 32'(event_valid), 32'd0);
        check("rst_event_x", 32'(event_x), 32'd0);
        check("rst_event_y", 32'(event_y), 32'd0);
        check("rst_event_buttons", 32'(event_buttons), 32'd0);
        check("rst_event_keys", 32'(event_keys), 32'd0);
        check("rst_pt_valid", 32'(passthrough_valid), 32'd0);
        check("rst_pt_byte", 32'(passthrough_byte), 32'd0);
        check("rst_error_count", 32'(error_count), 32'd0);

        // Reset mid-sequence: partial dropped, no error counted, back in idle.
        send_bytes(64'h1E85, 2, 0);
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        byte_in_valid = 1'b0;
        pending.delete();
        model_err = 0;
        last_ev   = '0;
        @(negedge clk);
        reset = 1'b0;
        chk_state("reset_mid_err");
        send_bytes(64'h8A8341, 3, 0);
        chk_state("after_reset_idle");

        send_bytes(64'h1E858A83, 4, 0);
        chk_state("valid_event");
        send_bytes(64'h1EFFBFF8, 4, 0);
        chk_state("modifier_map");
        send_bytes(64'h411E81818042, 6, 0);
        chk_state("passthrough");
        send_bytes(64'h1E85C0, 3, 0);
        chk_state("bad_y");
        send_bytes(64'h1E851E868781, 6, 0);
        chk_state("early_restart");
        for (int i = 0; i < 10; i++) send_bytes(64'h1E858A83, 4, 3);
        chk_state("gapped");
        send_bytes(64'h1E858A831E868781, 8, 0);
        chk_state("back_to_back");

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       send(8'h1E);
                    1:       send(8'h80 | 8'($urandom_range(0, 127)));
                    2:       send(8'h80 | 8'($urandom_range(0, 63)));
                    default: send(8'($urandom));
                endcase
            end else begin
                x = 8'h80 | 8'($urandom_range(0, 127));
                y = 8'h80 | 8'($urandom_range(0, 63));
                m = 8'h80 | 8'($urandom_range(0, 127));
                send_bytes({32'd0, 8'h1E, x, y, m}, 4, 3);
            end
            idle($urandom_range(0, 3));
        end
        chk_state("random");

        send(8'h1E);
        for (int i = 0; i < 300; i++) send(8'h1E);
        send(8'h00);
        chk_state("saturate");

        idle(3);
        check("events_drained", 32'(ev_q.size()), 32'd0);
        check("pt_drained", 32'(pt_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
